// File: rtl/decoder_seq.sv
// decoder_seq
//   Registered SEL_W-to-NUM_OUT one-hot decoder with valid/ready handshakes.
//   DIRECT mode decodes every accepted input code. SCAN mode walks a single
//   hot bit across the outputs at a programmable rate.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-high
//   mode       in   0 = DIRECT, 1 = SCAN (acted on from IDLE)
//   scan_div   in   SCAN step period minus 1, captured on entry to SCAN
//   in_valid   in   input code valid
//   in_ready   out  input code accepted when in_valid && in_ready
//   d          in   input code
//   out_valid  out  y holds a valid beat
//   out_ready  in   downstream accepts the beat when out_valid && out_ready
//   y          out  registered one-hot output (one-cold when inverted)
//   err        out  one-cycle pulse alongside the beat of an out-of-range code
//
// Build option
//   DECODER_ACTIVE_LOW_EN : drive y inverted (one-cold); the reset value and
//   the error beat then read as all-ones. Handshakes and err are unaffected.

module decoder_seq #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [DIV_W-1:0]   scan_div,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] y,
  output logic               err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN,
    ST_DRAIN
  } state_t;

  state_t state_reg, state_next;

  logic [NUM_OUT-1:0] y_reg;
  logic               out_valid_reg;
  logic               err_reg;
  logic               first_reg;   // first SCAN beat still owed
  logic [SEL_W-1:0]   idx_reg;     // next bit the walk will emit
  logic [DIV_W-1:0]   cnt_reg;
  logic [DIV_W-1:0]   div_reg;

  logic [NUM_OUT-1:0] code_hot;
  logic [NUM_OUT-1:0] scan_hot;
  logic               code_oob;
  logic               slot_free;
  logic               accept;
  logic               scan_tick;
  logic               scan_load;
  logic               idx_wrap;

  // An out-of-range code matches no output, so its decode is naturally all
  // zeros: the error beat and the range check come from the same vector.
  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_hot
      assign code_hot[gi] = (d == SEL_W'(gi));
      assign scan_hot[gi] = (idx_reg == SEL_W'(gi));
    end
  endgenerate

  assign code_oob  = ~|code_hot;
  assign slot_free = !out_valid_reg || out_ready;
  assign in_ready  = !rst && (state_reg == ST_DIRECT) && slot_free;
  assign accept    = in_valid && in_ready;
  // A tick that finds the slot busy stays pending because cnt_reg parks at
  // div_reg, so no step of the walk is ever dropped.
  assign scan_tick = first_reg || (cnt_reg == div_reg);
  assign scan_load = (state_reg == ST_SCAN) && slot_free && scan_tick;
  assign idx_wrap  = (idx_reg == SEL_W'(NUM_OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   state_next = mode ? ST_SCAN : ST_DIRECT;
      ST_DIRECT: if (mode)      state_next = ST_DRAIN;
      ST_SCAN:   if (!mode)     state_next = ST_DRAIN;
      ST_DRAIN:  if (slot_free) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg         <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      first_reg     <= 1'b0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      div_reg       <= '0;
    end else begin
      err_reg <= accept && code_oob;

      // Loading while the old beat is popped replaces it with no bubble.
      if (accept) begin
        y_reg         <= code_hot;
        out_valid_reg <= 1'b1;
      end else if (scan_load) begin
        y_reg         <= scan_hot;
        out_valid_reg <= 1'b1;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      // IDLE lasts one cycle, so capturing here samples scan_div on entry.
      if (state_reg == ST_IDLE) begin
        cnt_reg   <= '0;
        idx_reg   <= '0;
        first_reg <= 1'b1;
        div_reg   <= scan_div;
      end else if (state_reg == ST_SCAN) begin
        if (scan_load) begin
          cnt_reg   <= '0;
          first_reg <= 1'b0;
          idx_reg   <= idx_wrap ? '0 : idx_reg + 1'b1;
        end else if (!scan_tick) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign err       = err_reg;

`ifdef DECODER_ACTIVE_LOW_EN
  assign y = ~y_reg;
`else
  assign y = y_reg;
`endif

endmodule
